// File: rtl/debug_ctrl_pkg.sv
// Shared encodings for the debug run controller: command codes and FSM states.
package debug_ctrl_pkg;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_STEP = 2'b10,
      CMD_STOP = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10,
      ST_HALTED = 2'b11
   } state_e;

   // True when a valid strobe carries the given command code.
   function automatic logic cmd_is(input logic valid, input logic [1:0] code, input cmd_e want);
      return valid && (code == want);
   endfunction

endpackage

// File: rtl/debug_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int NBITS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [NBITS-1:0] count
);

   // Clear wins over increment; increment stops once every bit is set.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + NBITS'(1);
      end
   end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run controller: IDLE/RUN/STEP/HALTED FSM driving a registered clock-enable,
// with a saturating count of enabled cycles.
// Optional run limit: define RUN_LIMIT_EN to halt RUN after MAX_CYCLES cycles and
// raise a sticky o_timeout; without it o_timeout is tied low.
module debug_run_ctrl
   import debug_ctrl_pkg::*;
#(
   parameter int NBITS      = 32,
   parameter int MAX_CYCLES = 1024
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   input  logic             halt_detect,
   output logic             o_enable,
   output logic             o_step_done,
   output logic             o_halted,
   output logic             o_timeout,
   output logic [NBITS-1:0] cycle_count
);

   state_e r_state;
   state_e w_next_state;
   logic   r_enable;
   logic   r_step_done;
   logic   r_halted;
   logic   w_run;
   logic   w_step;
   logic   w_stop;
   logic   w_limit_hit;
   logic   w_clear;

   assign w_run   = cmd_is(cmd_valid, cmd, CMD_RUN);
   assign w_step  = cmd_is(cmd_valid, cmd, CMD_STEP);
   assign w_stop  = cmd_is(cmd_valid, cmd, CMD_STOP);
   // STOP while halted returns to IDLE and wipes the cycle count and timeout flag.
   assign w_clear = (r_state == ST_HALTED) && w_stop;

`ifdef RUN_LIMIT_EN
   localparam int RW = $clog2(MAX_CYCLES + 1);

   logic [RW-1:0] r_run_cnt;
   logic          r_timeout;

   // The last permitted RUN cycle is the one where the counter shows MAX_CYCLES-1.
   assign w_limit_hit = (r_state == ST_RUN) && (r_run_cnt == RW'(MAX_CYCLES - 1));

   // Run counter is held at zero outside RUN, so it always starts fresh on entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_run_cnt <= '0;
      end else if (r_state != ST_RUN) begin
         r_run_cnt <= '0;
      end else begin
         r_run_cnt <= r_run_cnt + RW'(1);
      end
   end

   // Timeout sets when the limit forces HALTED and stays set until STOP in HALTED.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_timeout <= 1'b0;
      end else if (w_limit_hit) begin
         r_timeout <= 1'b1;
      end else if (w_clear) begin
         r_timeout <= 1'b0;
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_limit_hit = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   // Next-state decode; halt (or run limit) outranks STOP while running.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_run) begin
               w_next_state = ST_RUN;
            end else if (w_step) begin
               w_next_state = ST_STEP;
            end
         end
         ST_RUN: begin
            if (halt_detect || w_limit_hit) begin
               w_next_state = ST_HALTED;
            end else if (w_stop) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_STEP: begin
            w_next_state = halt_detect ? ST_HALTED : ST_IDLE;
         end
         ST_HALTED: begin
            if (w_stop) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register with outputs decoded from the next state so they are pure flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_enable    <= 1'b0;
         r_step_done <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_enable    <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP);
         r_step_done <= (r_state == ST_STEP);
         r_halted    <= (w_next_state == ST_HALTED);
      end
   end

   assign o_enable    = r_enable;
   assign o_step_done = r_step_done;
   assign o_halted    = r_halted;

   sat_counter #(
      .NBITS (NBITS)
   ) u_cycle_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (r_enable),
      .clr   (w_clear),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed bench for debug_run_ctrl: a 32-bit instance (MAX_CYCLES=16) and a 4-bit
// instance share all stimulus. Define RUN_LIMIT_EN to cover the run-limit build.
module tb_debug_run_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd = 2'b00;
   logic        halt_detect = 1'b0;

   logic        en_a, sd_a, hl_a, to_a;
   logic [31:0] cnt_a;
   logic        en_b, sd_b, hl_b, to_b;
   logic [3:0]  cnt_b;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;

   always #5 clock = ~clock;

   debug_run_ctrl #(.NBITS(32), .MAX_CYCLES(16)) dut_a (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
      .halt_detect(halt_detect), .o_enable(en_a), .o_step_done(sd_a),
      .o_halted(hl_a), .o_timeout(to_a), .cycle_count(cnt_a)
   );

   debug_run_ctrl #(.NBITS(4)) dut_b (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
      .halt_detect(halt_detect), .o_enable(en_b), .o_step_done(sd_b),
      .o_halted(hl_b), .o_timeout(to_b), .cycle_count(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      tick();
      cmd_valid = 1'b0;
      cmd       = NOP;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1 reset = 1'b0;
   endtask

   task automatic check_a(input string tag, input logic en, input logic sd,
                          input logic hl, input logic to, input logic [31:0] cnt);
      check({tag, ".enable"},    32'(en_a), 32'(en));
      check({tag, ".step_done"}, 32'(sd_a), 32'(sd));
      check({tag, ".halted"},    32'(hl_a), 32'(hl));
      check({tag, ".timeout"},   32'(to_a), 32'(to));
      check({tag, ".count"},     cnt_a,     cnt);
   endtask

   initial begin
      // Reset held: everything zero.
      #3;
      check_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("reset.count_b", 32'(cnt_b), 32'd0);
      tick();
      reset = 1'b0;

      // Single STEP: enable for one cycle, done pulse next cycle, count 1.
      issue(STEP);
      check_a("step_c0", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check_a("step_c1", 1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
      tick();
      check_a("step_c2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
      check("step.count_b", 32'(cnt_b), 32'd1);

      // RUN then STOP after 8 enabled cycles; a STEP mid-run is ignored.
      pulse_reset();
      check("rst_async.count", cnt_a, 32'd0);
      issue(RUN);
      check_a("run_c0", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      ticks(2);
      issue(STEP);
      check_a("run_step_ign", 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
      ticks(4);
      check_a("run_c7", 1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
      issue(STOP);
      check_a("run_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd8);
      check("run_stop.count_b", 32'(cnt_b), 32'd8);

      // Halt and STOP together at cycle 5: halt wins.
      pulse_reset();
      issue(RUN);
      ticks(4);
      halt_detect = 1'b1;
      issue(STOP);
      halt_detect = 1'b0;
      check_a("halt_stop", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
      issue(RUN);
      check_a("halted_run_ign", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
      issue(STEP);
      check_a("halted_step_ign", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
      issue(STOP);
      check_a("halted_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Halt during STEP: HALTED, done still pulses.
      issue(STEP);
      halt_detect = 1'b1;
      tick();
      halt_detect = 1'b0;
      check_a("step_halt", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1);
      issue(STOP);
      check_a("step_halt_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Halt ignored in IDLE.
      halt_detect = 1'b1;
      tick();
      halt_detect = 1'b0;
      check_a("idle_halt_ign", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Long RUN: 4-bit instance saturates; 32-bit instance hits the limit if built.
      pulse_reset();
      issue(RUN);
      ticks(15);
      check_a("long_c15", 1'b1, 1'b0, 1'b0, 1'b0, 32'd15);
      check("long_c15.count_b", 32'(cnt_b), 32'd15);
      tick();
`ifdef RUN_LIMIT_EN
      check_a("limit_c16", 1'b0, 1'b0, 1'b1, 1'b1, 32'd16);
`else
      check_a("nolimit_c16", 1'b1, 1'b0, 1'b0, 1'b0, 32'd16);
`endif
      check("sat_c16.count_b", 32'(cnt_b), 32'd15);
      ticks(4);
`ifdef RUN_LIMIT_EN
      check_a("limit_c20", 1'b0, 1'b0, 1'b1, 1'b1, 32'd16);
`else
      check_a("nolimit_c20", 1'b1, 1'b0, 1'b0, 1'b0, 32'd20);
`endif
      check("sat_c20.count_b", 32'(cnt_b), 32'd15);
      check("sat_c20.enable_b", 32'(en_b), 32'd1);
      issue(STOP);
`ifdef RUN_LIMIT_EN
      check_a("limit_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`else
      check_a("nolimit_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd21);
`endif
      check("sat_stop.count_b", 32'(cnt_b), 32'd15);
      check("sat_stop.timeout_b", 32'(to_b), 32'd0);

      // Asynchronous reset mid-RUN clears outputs without a clock edge.
      pulse_reset();
      issue(RUN);
      ticks(2);
      #2 reset = 1'b1;
      #1;
      check_a("rst_mid_run", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("rst_mid_run.count_b", 32'(cnt_b), 32'd0);
      reset = 1'b0;

      // Reset mid-STEP: no done pulse afterwards.
      issue(STEP);
      check("mid_step.enable", 32'(en_a), 32'd1);
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      tick();
      check_a("rst_mid_step", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // First command right after reset is accepted.
      issue(RUN);
      check_a("post_rst_run", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/debug_run_ctrl.md
DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

Interface
REQ-001 Parameter NBITS, default 32, width of cycle_count.
REQ-002 Parameter MAX_CYCLES, default 1024, run-limit in cycles; used only with RUN_LIMIT_EN.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command strobe; cmd sampled on rising edge when high.
REQ-006 cmd  input  2  command code: NOP=00, RUN=01, STEP=10, STOP=11.
REQ-007 halt_detect  input  1  pipeline reports halt instruction retired.
REQ-008 o_enable  output  1  clock-enable to the clock_control block; high only in RUN and STEP.
REQ-009 o_step_done  output  1  one-cycle pulse when a STEP completes.
REQ-010 o_halted  output  1  high while in HALTED.
REQ-011 o_timeout  output  1  sticky run-limit flag.
REQ-012 cycle_count  output  NBITS  number of enabled cycles issued.

Function
REQ-013 FSM states: IDLE, RUN, STEP, HALTED; o_enable SHALL be a registered-state decode (no combinational path from cmd).
REQ-014 IDLE: RUN -> RUN; STEP -> STEP; STOP/NOP -> stay IDLE.
REQ-015 RUN: o_enable=1 every cycle; STOP -> IDLE at same edge; RUN/STEP ignored.
REQ-016 STEP: lasts exactly one cycle (o_enable high one cycle), then IDLE; o_step_done high in the cycle after STEP.
REQ-017 halt_detect=1 sampled in RUN or STEP -> HALTED at that edge; in STEP o_step_done still pulses.
REQ-018 Simultaneous halt_detect and STOP in RUN: halt wins, next state HALTED.
REQ-019 HALTED: o_enable=0; RUN/STEP ignored; STOP -> IDLE, clears cycle_count and o_timeout.
REQ-020 halt_detect ignored in IDLE and HALTED.
REQ-021 cycle_count increments by 1 on each edge where o_enable=1; saturates at 2^NBITS-1, no wrap.
REQ-022 Command latency: cmd accepted at edge N -> o_enable reflects new state after edge N (one cycle).

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, o_enable=0, o_step_done=0, o_halted=0, o_timeout=0, cycle_count=0, regardless of clock.
REQ-024 Reset mid-RUN or mid-STEP aborts with no o_step_done pulse; first command accepted on first rising edge after reset deasserts.

Configuration
REQ-025 Macro RUN_LIMIT_EN: when defined, a run counter clears on entering RUN and counts RUN cycles; on reaching MAX_CYCLES the FSM enters HALTED and sets o_timeout=1 (sticky until STOP in HALTED).
REQ-026 Without RUN_LIMIT_EN: no run counter is built, RUN continues indefinitely, o_timeout tied to 0.

Structure
REQ-027 Shared package debug_ctrl_pkg SHALL hold cmd encodings (CMD_NOP/RUN/STEP/STOP) and state encodings.
REQ-028 One sub-module sat_counter (parameter NBITS; inputs clock, reset, inc, clr; output count) SHALL implement cycle_count.

Verification
REQ-029 Reset, then STEP once -> o_enable high exactly 1 cycle, o_step_done pulse next cycle, cycle_count=1.
REQ-030 RUN, STOP after 8 cycles -> o_enable high 8 cycles, cycle_count=8, state IDLE, o_halted=0.
REQ-031 RUN, halt_detect and STOP asserted together at cycle 5 -> HALTED, o_halted=1, cycle_count=5; subsequent RUN ignored; STOP -> IDLE, cycle_count=0.
REQ-032 With RUN_LIMIT_EN, MAX_CYCLES=16: RUN with no halt -> HALTED after 16 enabled cycles, o_timeout=1, cycle_count=16.
REQ-033 NBITS=4: RUN 20 cycles -> cycle_count saturates at 15.
REQ-034 reset asserted mid-RUN between clock edges -> o_enable and cycle_count go to 0 immediately, no step_done pulse.
